// File: rtl/shift195_pkg.sv
// ---------------------------------------------------------------------------
// shift195_pkg
// Shared definitions for the 74LS195 serializer scheduler:
//   state_t         FSM states of the scheduler (IDLE, LOAD, SHIFT)
//   DEFAULT_LENGTH  default register width / bits per word
//   PE_ACTIVE       level of the register's parallel-enable pin that loads P
// ---------------------------------------------------------------------------
package shift195_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam int   DEFAULT_LENGTH = 4;

  // The 195 loads P when PE is low.
  localparam logic PE_ACTIVE = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter.
//   req[1:0]  in   request lines
//   en        in   arbitration window; no grant outside it
//   last      in   id of the most recent winner
//   gnt[1:0]  out  one-hot grant (or zero)
//   last_nxt  out  value of last for the next cycle (winner id on accept)
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       en,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       last_nxt
);

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the block can leave a value held and infer a latch.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;  // tie: the other one wins
      else              gnt = req;
    end
    last_nxt = (gnt != 2'b00) ? gnt[1] : last;
  end

endmodule

// File: rtl/shift195_sched.sv
// ---------------------------------------------------------------------------
// shift195_sched
// Shares one 74LS195-style parallel-load shift register between two word
// requesters, serializing each word MSB first on the register's Q3 pin and
// flagging which payload bit is on Q3 each cycle.
//   CP                  in   clock (same CP as the register)
//   MR                  in   asynchronous active-high reset
//   v0, v1 / d0, d1     in   word valid / word from requester 0 / 1
//   r0, r1              out  ready to requester 0 / 1 (combinational on v*)
//   P                   out  parallel data to the register
//   PE                  out  parallel enable to the register, active low
//   J, K                out  serial inputs (K is the 195's K-bar), = FILL
//   bit_valid           out  Q3 carries a payload bit
//   bit_first/bit_last  out  Q3 carries word bit LENGTH-1 / bit 0
//   bit_owner           out  requester owning the bit on Q3
// ---------------------------------------------------------------------------
module shift195_sched
  import shift195_pkg::*;
#(
  parameter int   LENGTH = DEFAULT_LENGTH,
  parameter logic FILL   = 1'b0
) (
  input  logic              CP,
  input  logic              MR,
  input  logic              v0,
  input  logic              v1,
  input  logic [LENGTH-1:0] d0,
  input  logic [LENGTH-1:0] d1,
  output logic              r0,
  output logic              r1,
  output logic [LENGTH-1:0] P,
  output logic              PE,
  output logic              J,
  output logic              K,
  output logic              bit_valid,
  output logic              bit_first,
  output logic              bit_last,
  output logic              bit_owner
);

  localparam int CW = $clog2(LENGTH);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            pend;
  logic            cur_owner;
  logic            pend_owner;
  logic            last_grant;
  logic            last_nxt;
  logic            window;
  logic            accept;
  logic            load;
  logic [1:0]      gnt;

  // Accept window: idle, or one bit before the end of a word with no word
  // queued, so the next word can load while the current last bit is on Q3.
  // Reset gates the window so ready stays low while MR is high.
  assign window = !MR && ((state == IDLE) ||
                          (state == SHIFT && cnt == CW'(1) && !pend));

  rr_arb2 u_arb (
    .req      ({v1, v0}),
    .en       (window),
    .last     (last_grant),
    .gnt      (gnt),
    .last_nxt (last_nxt)
  );

  assign accept = |gnt;
  assign r0     = gnt[0];
  assign r1     = gnt[1];
  assign J      = FILL;
  assign K      = FILL;

  // The register loads P on the edge that ends a LOAD cycle, or on the edge
  // that ends the last bit of a word when the next word is already queued.
  assign load = (state == LOAD) || (state == SHIFT && cnt == '0 && pend);

  // NOTE: state is reset asynchronously on MR; the register's own contents
  // need no reset because bit_valid masks Q3 until a fresh load.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) state <= IDLE;
    else    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    PE        = load ? PE_ACTIVE : ~PE_ACTIVE;
    bit_valid = 1'b0;
    bit_first = 1'b0;
    bit_last  = 1'b0;
    bit_owner = 1'b0;
    unique case (state)
      IDLE:  if (accept) state_nxt = LOAD;
      LOAD:  state_nxt = SHIFT;
      SHIFT: begin
        bit_valid = 1'b1;
        bit_first = (cnt == CW'(LENGTH - 1));
        bit_last  = (cnt == '0);
        bit_owner = cur_owner;
        if (cnt == '0 && !pend) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      cnt        <= '0;
      pend       <= 1'b0;
      P          <= '0;
      cur_owner  <= 1'b0;
      pend_owner <= 1'b0;
      last_grant <= 1'b1;   // requester 0 wins the first tie
    end else begin
      last_grant <= last_nxt;
      if (load) begin
        cur_owner <= pend_owner;
        pend      <= 1'b0;
        cnt       <= CW'(LENGTH - 1);
      end else if (state == SHIFT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      // Accept and load never coincide: the window excludes LOAD and cnt==0.
      if (accept) begin
        P          <= gnt[1] ? d1 : d0;
        pend_owner <= gnt[1];
        pend       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift195_sched.sv
// ---------------------------------------------------------------------------
// tb_shift195_sched
// Drives two schedulers (FILL=0 and FILL=1) from the same requesters, each
// feeding its own behavioural 74LS195 model. A timeline model of the
// schedule predicts ready, PE and the framed Q3 stream cycle by cycle.
// ---------------------------------------------------------------------------
module tb_shift195_sched;

  localparam int L = 4;

  logic         CP = 1'b0;
  logic         MR = 1'b1;
  logic         v0 = 1'b0, v1 = 1'b0;
  logic [L-1:0] d0 = '0,   d1 = '0;

  logic         r0_0, r1_0, PE_0, J_0, K_0, bv_0, bf_0, bl_0, bo_0;
  logic         r0_1, r1_1, PE_1, J_1, K_1, bv_1, bf_1, bl_1, bo_1;
  logic [L-1:0] P_0, P_1;

  shift195_sched #(.LENGTH(L), .FILL(1'b0)) u0 (
    .CP(CP), .MR(MR), .v0(v0), .v1(v1), .d0(d0), .d1(d1),
    .r0(r0_0), .r1(r1_0), .P(P_0), .PE(PE_0), .J(J_0), .K(K_0),
    .bit_valid(bv_0), .bit_first(bf_0), .bit_last(bl_0), .bit_owner(bo_0)
  );

  shift195_sched #(.LENGTH(L), .FILL(1'b1)) u1 (
    .CP(CP), .MR(MR), .v0(v0), .v1(v1), .d0(d0), .d1(d1),
    .r0(r0_1), .r1(r1_1), .P(P_1), .PE(PE_1), .J(J_1), .K(K_1),
    .bit_valid(bv_1), .bit_first(bf_1), .bit_last(bl_1), .bit_owner(bo_1)
  );

  always #5 CP = ~CP;

  int cyc = 0;
  always @(posedge CP) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---- behavioural 74LS195 (J / K-bar serial input) ----
  function automatic logic jk(input logic j, input logic kb, input logic q);
    case ({j, kb})
      2'b00:   return 1'b0;
      2'b11:   return 1'b1;
      2'b01:   return q;
      default: return ~q;
    endcase
  endfunction

  logic [L-1:0] q0, q1;
  always @(posedge CP or posedge MR) begin
    if (MR)        q0 <= '0;
    else if (!PE_0) q0 <= P_0;
    else           q0 <= {q0[L-2:0], jk(J_0, K_0, q0[0])};
  end
  always @(posedge CP or posedge MR) begin
    if (MR)        q1 <= '0;
    else if (!PE_1) q1 <= P_1;
    else           q1 <= {q1[L-2:0], jk(J_1, K_1, q1[0])};
  end

  // ---- timeline model: which bit belongs on Q3 in which cycle ----
  typedef struct packed { logic b; logic own; logic first; logic last; } slot_t;
  slot_t sched[int];
  bit    pelow[int];
  int    e_end  = -100;  // cycle of the last scheduled payload bit
  bit    last_g = 1'b1;

  // scenario capture
  logic [31:0] cap, cap1;
  logic [3:0]  own_cap;
  int cap_n, pe_low_n, r0_n, r1_n, fb_cyc, vfirst, vlast, fill_ones;
  bit fb_own;

  task automatic clear_cap();
    cap = '0; cap1 = '0; own_cap = '0; cap_n = 0; pe_low_n = 0;
    r0_n = 0; r1_n = 0; fb_cyc = -1; fb_own = 1'b0; vfirst = -1; vlast = -1;
    fill_ones = 0;
  endtask

  always @(negedge CP) begin : cmp
    int    t, start;
    bit    win, w0, w1, id;
    logic [L-1:0] w;
    slot_t s;
    t = cyc;
    if (MR) begin
      check("rst_r0", r0_0, 1'b0);
      check("rst_r1", r1_0, 1'b0);
      check("rst_pe", PE_0, 1'b1);
      check("rst_bv", {bv_0, bf_0, bl_0, bo_0, bv_1}, 5'b0);
      e_end  = -100;
      last_g = 1'b1;
      sched.delete();
      pelow.delete();
    end else begin
      win = (t > e_end) || (t == e_end - 1);
      w0 = 1'b0; w1 = 1'b0;
      if (win) begin
        if (v0 && v1) begin w0 = last_g;  w1 = !last_g; end
        else          begin w0 = v0;      w1 = v1;      end
      end
      check("r0", r0_0, w0);
      check("r1", r1_0, w1);
      check("r0_fill", r0_1, w0);
      check("r1_fill", r1_1, w1);
      if (r0_0) r0_n++;
      if (r1_0) r1_n++;
      if (w0 || w1) begin
        id    = w1;
        w     = w1 ? d1 : d0;
        start = (t > e_end) ? t + 2 : e_end + 1;
        pelow[start - 1] = 1'b1;
        for (int k = 0; k < L; k++)
          sched[start + k] = {w[L-1-k], id, k == 0, k == L - 1};
        e_end  = start + L - 1;
        last_g = id;
      end
      if (sched.exists(t)) begin
        s = sched[t];
        check("bit_valid", bv_0, 1'b1);
        check("bit_first", bf_0, s.first);
        check("bit_last",  bl_0, s.last);
        check("bit_owner", bo_0, s.own);
        check("q3",        q0[L-1], s.b);
        check("bit_valid_fill", bv_1, 1'b1);
        check("q3_fill",   q1[L-1], s.b);
        cap  = {cap[30:0],  q0[L-1]};
        cap1 = {cap1[30:0], q1[L-1]};
        cap_n++;
        if (bf_0) begin fb_cyc = t; fb_own = bo_0; own_cap = {own_cap[2:0], bo_0}; end
        if (!s.first && q1[0]) fill_ones++;
        if (vfirst < 0) vfirst = t;
        vlast = t;
      end else begin
        check("bit_valid_idle", {bv_0, bv_1}, 2'b00);
      end
      check("pe",      PE_0, !pelow.exists(t));
      check("pe_fill", PE_1, !pelow.exists(t));
      if (!PE_0) pe_low_n++;
      check("jk",      {J_0, K_0, J_1, K_1}, 4'b0011);
    end
  end

  // Present a word and hold it until ready (bounded); returns accept cycle.
  task automatic send(input bit id, input logic [L-1:0] wd, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    if (id) begin v1 = 1'b1; d1 = wd; end
    else    begin v0 = 1'b1; d0 = wd; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CP);
      if (id ? r1_0 : r0_0) begin got = 1'b1; acc = cyc; end
    end
    @(posedge CP); #1;
    if (id) v1 = 1'b0; else v0 = 1'b0;
    if (!got) check("send_timeout", 1'b0, 1'b1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int a, b, acc;
    clear_cap();

    // ---- reset state, ready gated while MR is high ----
    repeat (2) @(posedge CP);
    #1;
    v0 = 1'b1; d0 = 4'b1001;
    #1;
    check("lit_rst_r0", r0_0, 1'b0);
    check("lit_rst_pe", PE_0, 1'b1);
    check("lit_rst_p",  P_0, 4'b0000);
    @(posedge CP); #1;
    v0 = 1'b0;
    MR = 1'b0;
    @(posedge CP); #1;

    // ---- single word ----
    clear_cap();
    send(1'b0, 4'b1011, a);
    repeat (6) @(posedge CP); #1;
    check("single_q3",    cap[3:0], 4'b1011);
    check("single_nbits", cap_n, 4);
    check("single_pe",    pe_low_n, 1);
    check("single_r0",    r0_n, 1);
    check("single_first", fb_cyc, a + 2);
    check("single_last",  vlast, a + 5);

    // ---- back-to-back from requester 0 ----
    clear_cap();
    send(1'b0, 4'b1100, a);
    send(1'b0, 4'b0011, b);
    repeat (8) @(posedge CP); #1;
    check("b2b_q3",     cap[7:0], 8'b1100_0011);
    check("b2b_nbits",  cap_n, 8);
    check("b2b_span",   vlast - vfirst + 1, 8);
    check("b2b_acc2",   b, a + 4);
    check("b2b_pe",     pe_low_n, 2);

    // ---- late arrival at cnt==0 ----
    clear_cap();
    send(1'b0, 4'b1001, a);
    repeat (4) @(posedge CP); #1;     // cycle a+5: last bit of the word
    v1 = 1'b1; d1 = 4'b0111;
    @(negedge CP);
    check("late_no_ready", r1_0, 1'b0);
    @(posedge CP); #1;
    @(negedge CP);
    check("late_ready_next", r1_0, 1'b1);
    @(posedge CP); #1;
    v1 = 1'b0;
    repeat (6) @(posedge CP); #1;
    check("late_first_cyc", fb_cyc, a + 8);
    check("late_owner",     fb_own, 1'b1);
    check("late_q3",        cap[7:0], 8'b1001_0111);

    // ---- contention, both held valid ----
    clear_cap();
    v0 = 1'b1; d0 = 4'hA;
    v1 = 1'b1; d1 = 4'h5;
    acc = 0;
    for (int i = 0; i < 40 && acc < 4; i++) begin
      @(negedge CP);
      if (r0_0 || r1_0) acc++;
    end
    @(posedge CP); #1;
    v0 = 1'b0; v1 = 1'b0;
    repeat (8) @(posedge CP); #1;
    check("cont_acc",   acc, 4);
    check("cont_q3",    cap[15:0], 16'hA5A5);
    check("cont_owner", own_cap, 4'b0101);
    check("cont_span",  vlast - vfirst + 1, 16);

    // ---- reset mid-SHIFT (cnt==2) ----
    send(1'b0, 4'b1111, a);           // now in cycle a+1
    repeat (2) @(posedge CP);         // cycle a+3: second bit, cnt==2
    #2;
    MR = 1'b1;
    v0 = 1'b1; d0 = 4'b0110;
    #1;
    check("mid_rst_pe", PE_0, 1'b1);
    check("mid_rst_bits", {bv_0, bf_0, bl_0, bo_0}, 4'b0000);
    check("mid_rst_ready", {r0_0, r1_0}, 2'b00);
    check("mid_rst_p", P_0, 4'b0000);
    clear_cap();
    @(posedge CP); #3;
    MR = 1'b0;
    @(negedge CP);
    check("post_rst_ready", r0_0, 1'b1);
    @(posedge CP); #1;
    v0 = 1'b0;
    repeat (7) @(posedge CP); #1;
    check("post_rst_q3",    cap[3:0], 4'b0110);
    check("post_rst_nbits", cap_n, 4);

    // ---- FILL=1 instance, word 0000 ----
    clear_cap();
    send(1'b0, 4'b0000, a);
    repeat (6) @(posedge CP); #1;
    check("fill_q3",      cap1[3:0], 4'b0000);
    check("fill_q3_ref",  cap[3:0], 4'b0000);
    check("fill_q0_ones", fill_ones, 3);
    check("fill_jk",      {J_1, K_1}, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift195_sched.md
# shift195_sched

Two-requester scheduler that shares one SN74LS195A-style 4-bit parallel-load shift register as a serializer. It arbitrates round-robin between two parallel-word requesters and drives the register's P, PE, J and K pins. It tracks which payload bit is on the register's Q3 pin each cycle and flags it, so downstream logic samples Q3 as a framed MSB-first serial stream. It sits between the word producers and the register instance, both clocked by the same CP.

## Interface
Parameters:
- LENGTH, 4, register width and bits per word; must be >= 2.
- FILL, 0, bit driven on both J and K during shifts, so Q0 loads FILL.

Ports:
- CP  in  1  clock; all state changes on the rising edge.
- MR  in  1  reset, asynchronous, active-high.
- v0, v1  in  1  word valid from requester 0 / 1.
- d0, d1  in  LENGTH  word from requester 0 / 1; stable while valid.
- r0, r1  out  1  ready to requester 0 / 1; a word transfers when valid and ready are both high in a cycle.
- P  out  LENGTH  parallel data to the register.
- PE  out  1  parallel enable to the register, active-low, as on the 195.
- J, K  out  1  serial inputs to the register (K is the 195's K-bar); both equal FILL.
- bit_valid  out  1  Q3 carries a payload bit this cycle.
- bit_first, bit_last  out  1  Q3 carries word bit LENGTH-1 / bit 0.
- bit_owner  out  1  requester that owns the bit on Q3.

## Operation
- State registers:
  - FSM state: IDLE, LOAD, SHIFT.
  - cnt: LENGTH-1 down to 0.
  - pend: word held for load.
  - cur_owner and pend_owner.
  - last_grant.
- Arbitration:
  - Arbitration happens only in an accept window, defined as IDLE, or SHIFT with cnt==1 and pend empty.
  - If only one requester is valid, it wins.
  - If both are valid, the one not equal to last_grant wins.
  - r_i = window AND (i is the winner), so it is combinational on v0/v1; no ready outside the window.
  - On accept: capture the word into P and its id into pend_owner, set pend, and update last_grant.
- IDLE:
  - PE=1, bit_valid=0.
  - On accept, go to LOAD.
- LOAD, one cycle:
  - PE=0; the register loads P at the end of this cycle.
  - cur_owner <= pend_owner; clear pend.
  - Go to SHIFT with cnt=LENGTH-1.
- SHIFT:
  - PE=1, bit_valid=1; Q3 carries word[cnt].
  - bit_first = (cnt==LENGTH-1), bit_last = (cnt==0), bit_owner = cur_owner.
  - cnt decrements each cycle.
  - At cnt==0 with pend set: PE=0 in the same cycle, so the register loads while the last bit is on Q3. cur_owner <= pend_owner, clear pend, stay in SHIFT with cnt=LENGTH-1.
  - At cnt==0 with pend clear: go to IDLE.
- J=K=FILL in every state.
- Reset (MR=1), asynchronous:
  - state=IDLE, cnt=0, pend=0, P=0, PE=1, J=K=FILL.
  - r0=r1=0, all bit_* outputs 0.
  - last_grant=1, so requester 0 wins the first tie.
- Reset mid-word: the word in flight and any pending word are discarded. No partial-word completion. Register contents are ignored because bit_valid=0.

## Timing
- Accept in cycle a from IDLE:
  - PE=0 in cycle a+1.
  - Bits word[LENGTH-1..0] appear on Q3 in cycles a+2 .. a+LENGTH+1.
- Back-to-back:
  - The next word is accepted at cnt==1 and loaded at cnt==0.
  - Its first bit follows the previous last bit with no gap, giving LENGTH cycles per word.
- Latency from an accept in IDLE to the first bit: 2 cycles.
- A requester whose valid is held keeps winning only when the other is idle. Both continuously valid: grants alternate 0,1,0,1 with no bubbles.
- Valid dropping before ready is allowed; no transfer occurs.

## Structure
- Shared package shift195_pkg holds:
  - state enum (IDLE, LOAD, SHIFT)
  - default LENGTH = 4
  - the PE active-level constant (0).
- Sub-module rr_arb2: two-input round-robin arbiter with inputs req[1:0], en and last; outputs gnt[1:0] one-hot. It updates last on accept.
- The top module holds the FSM, the counter and the output registers. The bench instantiates shift195_sched plus a behavioural 195 model on the same CP.

## Test plan
- Reset mid-SHIFT (cnt=2) with MR pulsed 1 → all outputs return to reset values immediately; IDLE; next word 4'b0110 serializes cleanly.
- Single word: v0=1, d0=4'b1011 in IDLE → r0 pulses once; PE low one cycle; Q3 reads 1,0,1,1 with bit_first on the first and bit_last on the fourth; then IDLE.
- Back-to-back from requester 0: d0=4'b1100 then 4'b0011 → 8 consecutive bit_valid cycles, Q3 = 1,1,0,0,0,0,1,1; PE low at the 4th bit.
- Contention: v0=v1=1 held, d0=4'hA, d1=4'h5 → owners alternate 0,1,0,1 starting with 0; Q3 = 1010 0101 1010 ….
- Late arrival: v1 asserted only at cnt==0 → no ready; IDLE next; word loads two cycles later with bit_owner=1.
- FILL=1, single word 4'b0000 → Q3 = 0,0,0,0; Q0 samples 1 during the shifts.
